// File: rtl/fixed_point_matrix_dot_vector_stream.sv
// Signed fixed-point matrix x vector engine: internal weight/bias tables, MULTS-wide MAC per beat,
// round-half-up, saturation and valid/ready row streaming. Define RELU_OUTPUT_EN to clamp negatives to 0.
module fixed_point_matrix_dot_vector_stream #(
  parameter int BITS   = 16,
  parameter int FRAC   = 8,
  parameter int WIDTH  = 40,
  parameter int HEIGHT = 10,
  parameter int MULTS  = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    load_matrix,
  input  logic [MULTS*BITS-1:0]   matrix_a_in,
  input  logic                    load_bias,
  input  logic [BITS-1:0]         bias_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [MULTS*BITS-1:0]   vector_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BITS-1:0]         c,
  output logic                    out_last,
  output logic                    busy
);

  localparam int B     = WIDTH / MULTS;
  localparam int DEPTH = HEIGHT * B;
  localparam int PW    = 2 * BITS;
  localparam int AW    = 2 * BITS + $clog2(WIDTH) + 1;
  localparam int SW    = AW + 1;
  localparam int WAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int KW    = (B > 1) ? $clog2(B) : 1;

  localparam logic [WAW-1:0]       WADDR_LAST = WAW'(DEPTH - 1);
  localparam logic [RW-1:0]        ROW_LAST   = RW'(HEIGHT - 1);
  localparam logic [KW-1:0]        K_LAST     = KW'(B - 1);
  localparam logic signed [SW-1:0] HALF       = SW'(1) << (FRAC - 1);

  typedef enum logic [1:0] {IDLE, LOAD_VEC, COMPUTE, EMIT} state_t;

  state_t state;

  logic [MULTS*BITS-1:0] wmem     [DEPTH];
  logic [MULTS*BITS-1:0] vbuf     [B];
  logic [BITS-1:0]       bias_tab [HEIGHT];

  logic [WAW-1:0]        waddr;
  logic [WAW-1:0]        raddr;
  logic [RW-1:0]         baddr;
  logic [RW-1:0]         row;
  logic [KW-1:0]         vcount;
  logic [KW-1:0]         k;
  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  acc_sum;
  logic [MULTS*BITS-1:0] wbeat;
  logic [MULTS*BITS-1:0] vbeat;
  logic signed [PW-1:0]  wa;
  logic signed [PW-1:0]  vb;
  logic signed [PW-1:0]  prod;
  logic signed [SW-1:0]  pre;
  logic signed [SW-1:0]  shifted;
  logic [BITS-1:0]       sat;
  logic [BITS-1:0]       result;
  logic                  idle;
  logic                  hs;
  logic                  mload;

  assign idle     = (state == IDLE);
  assign busy     = !idle;
  // Loads take priority: the vector port stalls whenever either load strobe is high.
  assign in_ready = rstn && (idle || state == LOAD_VEC) && !load_matrix && !load_bias;
  assign hs       = in_valid && in_ready;
  assign mload    = rstn && idle && load_matrix;

  assign raddr = WAW'(int'(row) * B + int'(k));
  assign wbeat = wmem[raddr];
  assign vbeat = vbuf[k];

  always_comb begin
    acc_sum = (k == '0) ? '0 : acc;
    wa      = '0;
    vb      = '0;
    prod    = '0;
    for (int unsigned i = 0; i < MULTS; i++) begin
      wa      = PW'($signed(wbeat[i*BITS +: BITS]));
      vb      = PW'($signed(vbeat[i*BITS +: BITS]));
      prod    = wa * vb;
      acc_sum = acc_sum + AW'(prod);
    end
  end

  // Bias is aligned to the product scale before rounding; the shift then returns to output Q format.
  always_comb begin
    pre     = SW'(acc_sum) + (SW'($signed(bias_tab[row])) <<< FRAC) + HALF;
    shifted = pre >>> FRAC;
    if (shifted[SW-1:BITS-1] == '0 || shifted[SW-1:BITS-1] == '1)
      sat = shifted[BITS-1:0];
    else if (shifted[SW-1])
      sat = {1'b1, {(BITS-1){1'b0}}};
    else
      sat = {1'b0, {(BITS-1){1'b1}}};
    result = sat;
`ifdef RELU_OUTPUT_EN
    if (sat[BITS-1])
      result = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (mload)
      wmem[waddr] <= matrix_a_in;
  end

  always_ff @(posedge clk) begin
    if (hs)
      vbuf[idle ? '0 : vcount] <= vector_b;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      waddr     <= '0;
      baddr     <= '0;
      row       <= '0;
      k         <= '0;
      vcount    <= '0;
      acc       <= '0;
      c         <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      bias_tab  <= '{default: '0};
    end else begin
      if (idle && load_matrix)
        waddr <= (waddr == WADDR_LAST) ? '0 : waddr + 1'b1;
      else if (!load_matrix)
        waddr <= '0;

      if (idle && load_bias) begin
        bias_tab[baddr] <= bias_in;
        baddr           <= (baddr == ROW_LAST) ? '0 : baddr + 1'b1;
      end else if (!load_bias) begin
        baddr <= '0;
      end

      case (state)
        IDLE: begin
          if (hs) begin
            if (B == 1) begin
              state  <= COMPUTE;
              row    <= '0;
              k      <= '0;
              vcount <= '0;
            end else begin
              state  <= LOAD_VEC;
              vcount <= KW'(1);
            end
          end
        end
        LOAD_VEC: begin
          if (hs) begin
            if (vcount == K_LAST) begin
              state  <= COMPUTE;
              row    <= '0;
              k      <= '0;
              vcount <= '0;
            end else begin
              vcount <= vcount + 1'b1;
            end
          end
        end
        COMPUTE: begin
          acc <= acc_sum;
          if (k == K_LAST) begin
            k         <= '0;
            c         <= result;
            out_valid <= 1'b1;
            out_last  <= (row == ROW_LAST);
            state     <= EMIT;
          end else begin
            k <= k + 1'b1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (row == ROW_LAST) begin
              row   <= '0;
              state <= IDLE;
            end else begin
              row   <= row + 1'b1;
              state <= COMPUTE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_matrix_dot_vector_stream.sv
// Directed + randomized bench for fixed_point_matrix_dot_vector_stream (WIDTH=8, HEIGHT=4, MULTS=2).
module tb_fixed_point_matrix_dot_vector_stream;

  localparam int BITS = 16;
  localparam int FRAC = 8;
  localparam int WID  = 8;
  localparam int HGT  = 4;
  localparam int ML   = 2;
  localparam int NB   = WID / ML;

  logic                 clk;
  logic                 rstn;
  logic                 load_matrix;
  logic [ML*BITS-1:0]   matrix_a_in;
  logic                 load_bias;
  logic [BITS-1:0]      bias_in;
  logic                 in_valid;
  logic                 in_ready;
  logic [ML*BITS-1:0]   vector_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [BITS-1:0]      c;
  logic                 out_last;
  logic                 busy;

  int vectors;
  int miscompares;

  int w    [HGT][WID];
  int v    [WID];
  int bias [HGT];

  fixed_point_matrix_dot_vector_stream #(
    .BITS(BITS), .FRAC(FRAC), .WIDTH(WID), .HEIGHT(HGT), .MULTS(ML)
  ) dut (
    .clk(clk), .rstn(rstn),
    .load_matrix(load_matrix), .matrix_a_in(matrix_a_in),
    .load_bias(load_bias), .bias_in(bias_in),
    .in_valid(in_valid), .in_ready(in_ready), .vector_b(vector_b),
    .out_valid(out_valid), .out_ready(out_ready), .c(c),
    .out_last(out_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer dot product, bias scaled into product Q format, floor-shift after +half.
  function automatic logic [BITS-1:0] model_row(input int r);
    longint acc;
    longint t;
    acc = 0;
    for (int j = 0; j < WID; j++) acc += longint'(w[r][j]) * longint'(v[j]);
    t = acc + longint'(bias[r]) * (longint'(1) << FRAC) + (longint'(1) << (FRAC - 1));
    t = t >>> FRAC;
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
`ifdef RELU_OUTPUT_EN
    if (t < 0) t = 0;
`endif
    return BITS'(t);
  endfunction

  function automatic int rnd_val(input bit full);
    if (full) return int'($urandom_range(0, 65535)) - 32768;
    return int'($urandom_range(0, 1023)) - 512;
  endfunction

  // Writes all weight beats row-major; biases go in during the first HGT cycles alongside.
  task automatic load_all(input bit with_valid);
    for (int a = 0; a < HGT * NB; a++) begin
      @(negedge clk);
      load_matrix = 1'b1;
      matrix_a_in = {16'(w[a / NB][(a % NB) * 2 + 1]), 16'(w[a / NB][(a % NB) * 2])};
      load_bias   = (a < HGT);
      bias_in     = (a < HGT) ? 16'(bias[a]) : 16'h0;
      if (with_valid) begin
        in_valid = 1'b1;
        vector_b = {16'($urandom), 16'($urandom)};
        #1;
        check("prio_in_ready", 32'(in_ready), 32'd0);
        check("prio_busy", 32'(busy), 32'd0);
      end
    end
    @(negedge clk);
    load_matrix = 1'b0;
    load_bias   = 1'b0;
    in_valid    = 1'b0;
  endtask

  task automatic send_vector(input bit gaps);
    int guard;
    int lat;
    for (int kk = 0; kk < NB; kk++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      vector_b = {16'(v[kk * 2 + 1]), 16'(v[kk * 2])};
      #1;
      guard = 0;
      while (!in_ready && guard < 50) begin
        @(negedge clk);
        #1;
        guard++;
      end
      check("vec_handshake", 32'(in_ready), 32'd1);
    end
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      lat++;
    end while (!out_valid && lat < 50);
    check("first_latency", 32'(lat), 32'(NB + 1));
  endtask

  task automatic collect(input int nrows, input int hold_row, input int hold_n, input bit rnd);
    int row;
    int guard;
    int held;
    bit rdy;
    row   = 0;
    guard = 0;
    held  = 0;
    while (row < nrows && guard < 1000) begin
      if (out_valid) begin
        check($sformatf("c_row%0d", row), 32'(c), 32'(model_row(row)));
        check($sformatf("last_row%0d", row), 32'(out_last), 32'(row == HGT - 1));
        check("emit_in_ready", 32'(in_ready), 32'd0);
        rdy = 1'b1;
        if (row == hold_row && held < hold_n) begin
          rdy = 1'b0;
          held++;
        end else if (rnd) begin
          rdy = 1'($urandom_range(0, 1));
        end
        out_ready = rdy;
        if (rdy) row++;
      end else begin
        check("last_no_valid", 32'(out_last), 32'd0);
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(negedge clk);
      #1;
      guard++;
    end
    out_ready = 1'b0;
    check("rows_done", 32'(row), 32'(nrows));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstn        = 1'b0;
    load_matrix = 1'b0;
    matrix_a_in = '0;
    load_bias   = 1'b0;
    bias_in     = '0;
    in_valid    = 1'b0;
    vector_b    = '0;
    out_ready   = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_c", 32'(c), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rstn = 1'b1;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Unit weights and vector: every row is 8.0, with a 10-cycle stall on row 1.
    for (int r = 0; r < HGT; r++) begin
      bias[r] = 0;
      for (int j = 0; j < WID; j++) w[r][j] = 256;
    end
    for (int j = 0; j < WID; j++) v[j] = 256;
    load_all(1'b0);
    send_vector(1'b0);
    collect(HGT, 1, 10, 1'b0);

    // Reset while row 2 is computing, then rerun on the retained weights.
    send_vector(1'b0);
    collect(2, -1, 0, 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    send_vector(1'b1);
    collect(HGT, -1, 0, 1'b1);

    // Rounding and negative bias, loaded with in_valid held high to exercise load priority.
    for (int r = 0; r < HGT; r++) begin
      bias[r] = 0;
      for (int j = 0; j < WID; j++) w[r][j] = 0;
    end
    for (int j = 0; j < WID; j++) v[j] = 0;
    w[0][0] = 128;
    v[0]    = 1;
    bias[2] = -256;
    load_all(1'b1);
    send_vector(1'b0);
    collect(HGT, -1, 0, 1'b0);

    // Positive then negative saturation.
    for (int r = 0; r < HGT; r++) begin
      bias[r] = 0;
      for (int j = 0; j < WID; j++) w[r][j] = 32767;
    end
    for (int j = 0; j < WID; j++) v[j] = 32767;
    load_all(1'b0);
    send_vector(1'b0);
    collect(HGT, -1, 0, 1'b0);
    for (int j = 0; j < WID; j++) v[j] = -32767;
    send_vector(1'b1);
    collect(HGT, -1, 0, 1'b0);

    // Randomized rounds: alternating small and full-range operands.
    for (int rnd = 0; rnd < 6; rnd++) begin
      for (int r = 0; r < HGT; r++) begin
        bias[r] = rnd_val(rnd[0]);
        for (int j = 0; j < WID; j++) w[r][j] = rnd_val(rnd[0]);
      end
      for (int j = 0; j < WID; j++) v[j] = rnd_val(rnd[0]);
      load_all(1'b0);
      send_vector(1'b1);
      collect(HGT, -1, 0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fixed_point_matrix_dot_vector_stream.md
Name: fixed_point_matrix_dot_vector_stream

Overview:
- Signed fixed-point matrix × vector engine. Successor to the integer dot-product array.
- Holds a HEIGHT×WIDTH weight matrix and a HEIGHT-entry bias table internally.
- Time-multiplexes MULTS multipliers over rows and streams one result per row with valid/ready backpressure.
- Sits between layer-weight loaders and the next neural-network layer. Adds fixed-point rounding, saturation, bias and flow control.

Parameters:
- BITS, 16, element width (signed two's complement), for weights, vector, bias and output.
- FRAC, 8, fractional bits of every operand and of the output (FRAC ≥ 1).
- WIDTH, 40, vector length / matrix columns. Must be a multiple of MULTS.
- HEIGHT, 10, matrix rows / output count. No upper bound relative to WIDTH.
- MULTS, 2, elements consumed per beat (parallel multipliers).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- load_matrix  in  1  weight-load strobe; one beat written per cycle while high
- matrix_a_in  in  MULTS×BITS  weight beat, row-major, element 0 = lowest column
- load_bias  in  1  bias-load strobe; one bias written per cycle while high
- bias_in  in  BITS  bias value (same Q format as output)
- in_valid  in  1  vector beat valid
- in_ready  out  1  vector beat accepted when in_valid && in_ready
- vector_b  in  MULTS×BITS  vector beat
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- c  out  BITS  row result
- out_last  out  1  high with the result of row HEIGHT-1
- busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: one clock `clk`; reset `rstn` is synchronous and active-low.
- B = WIDTH/MULTS beats per row.
- Reset values: out_valid=0, out_last=0, c=0, busy=0, in_ready=0 in the reset cycle, state=IDLE, all counters=0, bias table=0. Weight memory is not cleared.
- Matrix load (IDLE only):
  - Each load_matrix cycle writes matrix_a_in at address waddr, then waddr increments.
  - waddr wraps to 0 after HEIGHT·B−1.
  - waddr returns to 0 on any cycle load_matrix is low.
- Bias load (IDLE only):
  - Same rules with baddr over 0..HEIGHT−1.
  - load_matrix and load_bias may be high together; both writes occur.
- Loads outside IDLE are ignored and counters are unchanged.
- in_ready = (state∈{IDLE, LOAD_VEC}) && !load_matrix && !load_bias. Loads have priority over vector input.
- State machine:
  - IDLE→LOAD_VEC: on first vector handshake, beat stored, vcount=1. If B==1, go directly to COMPUTE.
  - LOAD_VEC: each handshake stores a beat. At beat B−1 → COMPUTE with row=0, k=0. Gaps in in_valid are allowed.
  - COMPUTE: per cycle, acc += Σ w[row][k·MULTS+i]·v[k·MULTS+i]. acc is cleared at k=0. When k=B−1, the next state is EMIT.
  - EMIT: out_valid=1 and c=result(row), stable until out_ready. On handshake: if row==HEIGHT−1 → IDLE, else row+1 → COMPUTE.
- Latency: out_valid for row 0 rises exactly B+1 cycles after the last vector handshake. Each row takes B+1 cycles with out_ready held high.
- Arithmetic:
  - Products are 2·BITS signed.
  - acc has 2·BITS+$clog2(WIDTH)+1 bits and does not overflow.
  - result = sat_BITS((acc + (bias<<FRAC) + (1<<(FRAC−1))) >>> FRAC). This is round-half-up toward +∞.
  - Saturate to [−2^(BITS−1), 2^(BITS−1)−1].
- out_last = out_valid && row==HEIGHT−1.
- The vector buffer holds until the next LOAD_VEC. A new vector is not accepted until the last row is handshaken.
- Reset mid-operation: next cycle is IDLE, out_valid=0, partial vector discarded. The weight memory keeps its contents.

Optional Feature:
- Macro RELU_OUTPUT_EN.
- Defined: a negative saturated result is replaced by 0 before c. Latency is unchanged.
- Undefined: signed result passes through unmodified.

Test Plan:
- All parameters at defaults except WIDTH=8, HEIGHT=4, MULTS=2 (B=4).
- All weights 256 (1.0), vector all 256, bias 0 → four results c=2048 (8.0). out_last only on the 4th. First out_valid 5 cycles after the last vector beat.
- Row r weights all 0x7FFF, vector all 0x7FFF → c=0x7FFF. Negate vector → c=0x8000 (RELU_OUTPUT_EN defined: c=0).
- Rounding: only w[0][0]=128 and v[0]=1 nonzero, bias[0]=0 → c=1 for row 0, c=0 for rows 1–3. Bias[2]=−256 → row 2 c=0xFF00.
- Backpressure: out_ready low 10 cycles during row 1's EMIT → c held stable, in_ready=0, no row lost. Rows 2–3 follow the ready rise.
- Priority: load_matrix asserted with in_valid in IDLE → in_ready=0, no vector beat consumed, weights written in order.
- rstn low for 1 cycle mid-COMPUTE on row 2 → out_valid=0 and busy=0 next cycle. A fresh vector reuses the retained weights and reproduces the first scenario's results.
